// File: rtl/rob_pkg.sv
// Reorder-buffer shared types: parameter defaults, index width, entry layout.
// Field widths come from the shared range defines, with local fallbacks.
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif
`ifndef LREG_RANGE
`define LREG_RANGE 4:0
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif

package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_ENQ_W = 2;
  localparam int ROB_WB_W  = 4;
  localparam int ROB_CMT_W = 2;

  typedef logic [`PC_RANGE]   pc_t;
  typedef logic [`LREG_RANGE] lreg_t;
  typedef logic [`PREG_RANGE] preg_t;

  typedef struct packed {
    pc_t         pc;
    logic [31:0] instr;
    lreg_t       lrd;
    preg_t       prd;
    preg_t       old_prd;
    logic        need_to_wb;
  } rob_entry_t;

  // Slot index plus one wrap bit in the MSB.
  function automatic int rob_iw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_slot.sv
// One ROB entry: valid/complete/skip flags and the instruction payload.
// Ports: i_enq/i_enq_data allocate, i_wb/i_wb_skip complete, i_cmt retire, i_flush kill.
module rob_slot
  import rob_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_enq,
  input  rob_entry_t i_enq_data,
  input  logic       i_wb,
  input  logic       i_wb_skip,
  input  logic       i_cmt,
  input  logic       i_flush,
  output logic       o_valid,
  output logic       o_complete,
  output logic       o_skip,
  output rob_entry_t o_data
);

  logic       r_valid;
  logic       r_complete;
  logic       r_skip;
  rob_entry_t r_data;

  // Retire beats a late writeback to the same entry; writeback
  // only lands on an entry that is already live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_complete <= 1'b0;
      r_skip     <= 1'b0;
      r_data     <= '0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
      r_complete <= 1'b0;
      r_skip     <= 1'b0;
    end else if (i_enq) begin
      r_valid    <= 1'b1;
      r_complete <= 1'b0;
      r_skip     <= 1'b0;
      r_data     <= i_enq_data;
    end else if (i_cmt) begin
      r_valid    <= 1'b0;
      r_complete <= 1'b0;
    end else if (i_wb && r_valid) begin
      r_complete <= 1'b1;
      r_skip     <= i_wb_skip;
    end
  end

  assign o_valid    = r_valid;
  assign o_complete = r_complete;
  assign o_skip     = r_skip;
  assign o_data     = r_data;

endmodule

// File: rtl/rob_queue.sv
// In-order reorder buffer: multi-lane enqueue, multi-port writeback, in-order commit.
// Ports: enq_* allocate, wb_* complete, commit_* retire, flush/count/empty/full status.
module rob_queue
  import rob_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH,
  parameter  int ENQ_W = ROB_ENQ_W,
  parameter  int WB_W  = ROB_WB_W,
  parameter  int CMT_W = ROB_CMT_W,
  localparam int IW    = rob_iw(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [ENQ_W-1:0]             enq_valid,
  input  pc_t  [ENQ_W-1:0]             enq_pc,
  input  logic [ENQ_W-1:0][31:0]       enq_instr,
  input  lreg_t [ENQ_W-1:0]            enq_lrd,
  input  preg_t [ENQ_W-1:0]            enq_prd,
  input  preg_t [ENQ_W-1:0]            enq_old_prd,
  input  logic [ENQ_W-1:0]             enq_need_to_wb,
  output logic                         enq_ready,
  output logic [ENQ_W-1:0][IW-1:0]     enq_robidx,
  input  logic [WB_W-1:0]              wb_valid,
  input  logic [WB_W-1:0][IW-1:0]      wb_robidx,
  input  logic [WB_W-1:0]              wb_skip,
  output logic [CMT_W-1:0]             commit_valid,
  output pc_t  [CMT_W-1:0]             commit_pc,
  output logic [CMT_W-1:0][31:0]       commit_instr,
  output lreg_t [CMT_W-1:0]            commit_lrd,
  output preg_t [CMT_W-1:0]            commit_prd,
  output preg_t [CMT_W-1:0]            commit_old_prd,
  output logic [CMT_W-1:0]             commit_need_to_wb,
  output logic [CMT_W-1:0]             commit_skip,
  input  logic                         flush,
  output logic [IW-1:0]                count,
  output logic                         empty,
  output logic                         full
);

  localparam int SW = IW - 1;
  typedef logic [IW-1:0] idx_t;

  idx_t r_head;
  idx_t r_tail;
  idx_t r_count;

  logic [DEPTH-1:0] w_s_valid;
  logic [DEPTH-1:0] w_s_cmpl;
  logic [DEPTH-1:0] w_s_skip;
  logic [DEPTH-1:0] w_s_enq;
  logic [DEPTH-1:0] w_s_wb;
  logic [DEPTH-1:0] w_s_wbskip;
  logic [DEPTH-1:0] w_s_cmt;
  rob_entry_t       w_s_data     [DEPTH];
  rob_entry_t       w_s_enq_data [DEPTH];

  logic [ENQ_W-1:0] w_enq_fire;
  logic [CMT_W-1:0] w_cmt;
  idx_t             w_enq_num;
  idx_t             w_cmt_num;

  // Space check uses registered occupancy only.
  assign enq_ready = (idx_t'(DEPTH) - r_count) >= idx_t'(ENQ_W);

  // A lane fires only if every lower lane also requested.
  always_comb begin
    logic l_run;
    l_run     = enq_ready & ~flush;
    w_enq_num = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      l_run         = l_run & enq_valid[i];
      w_enq_fire[i] = l_run;
      w_enq_num     = w_enq_num + idx_t'(l_run);
      enq_robidx[i] = r_tail + idx_t'(i);
    end
  end

  // Commit stops at the first entry that is not valid and complete.
  always_comb begin
    logic l_run;
    idx_t l_idx;
    l_run     = ~flush;
    l_idx     = '0;
    w_cmt_num = '0;
    for (int j = 0; j < CMT_W; j++) begin
      l_idx    = r_head + idx_t'(j);
      l_run    = l_run & w_s_valid[l_idx[SW-1:0]]
                       & w_s_cmpl[l_idx[SW-1:0]];
      w_cmt[j] = l_run;
      w_cmt_num = w_cmt_num + idx_t'(l_run);
      commit_pc[j]         = w_s_data[l_idx[SW-1:0]].pc;
      commit_instr[j]      = w_s_data[l_idx[SW-1:0]].instr;
      commit_lrd[j]        = w_s_data[l_idx[SW-1:0]].lrd;
      commit_prd[j]        = w_s_data[l_idx[SW-1:0]].prd;
      commit_old_prd[j]    = w_s_data[l_idx[SW-1:0]].old_prd;
      commit_need_to_wb[j] = w_s_data[l_idx[SW-1:0]].need_to_wb;
      commit_skip[j]       = w_s_skip[l_idx[SW-1:0]];
    end
  end

  assign commit_valid = w_cmt;

  // Lane/port to slot decode; later writeback ports override skip.
  always_comb begin
    idx_t l_idx;
    l_idx      = '0;
    w_s_enq    = '0;
    w_s_wb     = '0;
    w_s_wbskip = '0;
    w_s_cmt    = '0;
    for (int s = 0; s < DEPTH; s++) begin
      w_s_enq_data[s] = '0;
    end
    for (int i = 0; i < ENQ_W; i++) begin
      l_idx = r_tail + idx_t'(i);
      if (w_enq_fire[i]) begin
        w_s_enq[l_idx[SW-1:0]] = 1'b1;
        w_s_enq_data[l_idx[SW-1:0]] = '{
          pc:         enq_pc[i],
          instr:      enq_instr[i],
          lrd:        enq_lrd[i],
          prd:        enq_prd[i],
          old_prd:    enq_old_prd[i],
          need_to_wb: enq_need_to_wb[i]
        };
      end
    end
    for (int k = 0; k < WB_W; k++) begin
      if (wb_valid[k]) begin
        w_s_wb[wb_robidx[k][SW-1:0]]     = 1'b1;
        w_s_wbskip[wb_robidx[k][SW-1:0]] = wb_skip[k];
      end
    end
    for (int j = 0; j < CMT_W; j++) begin
      l_idx = r_head + idx_t'(j);
      if (w_cmt[j]) begin
        w_s_cmt[l_idx[SW-1:0]] = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    rob_slot u_slot (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_enq      (w_s_enq[s]),
      .i_enq_data (w_s_enq_data[s]),
      .i_wb       (w_s_wb[s]),
      .i_wb_skip  (w_s_wbskip[s]),
      .i_cmt      (w_s_cmt[s]),
      .i_flush    (flush),
      .o_valid    (w_s_valid[s]),
      .o_complete (w_s_cmpl[s]),
      .o_skip     (w_s_skip[s]),
      .o_data     (w_s_data[s])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_cmt_num;
      r_tail  <= r_tail + w_enq_num;
      r_count <= r_count + w_enq_num - w_cmt_num;
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == idx_t'(DEPTH));

endmodule

// File: tb/tb_rob_queue.sv
// Scoreboard bench for rob_queue (DEPTH=8): queue-based reference model,
// directed corner cases followed by random enq/wb/flush traffic.
module tb_rob_queue;
  import rob_pkg::*;

  localparam int D = 8;

  logic clock;
  logic reset_n;
  logic [1:0]        enq_valid;
  pc_t  [1:0]        enq_pc;
  logic [1:0][31:0]  enq_instr;
  lreg_t [1:0]       enq_lrd;
  preg_t [1:0]       enq_prd;
  preg_t [1:0]       enq_old_prd;
  logic [1:0]        enq_need_to_wb;
  logic              enq_ready;
  logic [1:0][3:0]   enq_robidx;
  logic [3:0]        wb_valid;
  logic [3:0][3:0]   wb_robidx;
  logic [3:0]        wb_skip;
  logic [1:0]        commit_valid;
  pc_t  [1:0]        commit_pc;
  logic [1:0][31:0]  commit_instr;
  lreg_t [1:0]       commit_lrd;
  preg_t [1:0]       commit_prd;
  preg_t [1:0]       commit_old_prd;
  logic [1:0]        commit_need_to_wb;
  logic [1:0]        commit_skip;
  logic              flush;
  logic [3:0]        count;
  logic              empty;
  logic              full;

  rob_queue #(.DEPTH(8), .ENQ_W(2), .WB_W(4), .CMT_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_pc(enq_pc),
    .enq_instr(enq_instr), .enq_lrd(enq_lrd),
    .enq_prd(enq_prd), .enq_old_prd(enq_old_prd),
    .enq_need_to_wb(enq_need_to_wb),
    .enq_ready(enq_ready), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_robidx(wb_robidx),
    .wb_skip(wb_skip),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_lrd(commit_lrd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .commit_need_to_wb(commit_need_to_wb),
    .commit_skip(commit_skip),
    .flush(flush), .count(count),
    .empty(empty), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] idx;
    rob_entry_t d;
    bit         cmp;
    bit         skp;
  } ment_t;

  typedef struct {
    int         cnt;
    bit         rdy;
    logic [3:0] r0;
    logic [3:0] r1;
    int         ncm;
  } st_t;

  typedef struct {
    rob_entry_t d;
    bit         skp;
  } cm_t;

  ment_t mq[$];
  st_t   exp_st[$];
  cm_t   exp_cm[$];
  int    mtail;
  int    checks;
  int    errors;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: ordered list of in-flight instructions.
  task automatic predict(input logic [1:0] ev, input logic [3:0] wv,
                         input logic [3:0][3:0] wi, input logic [3:0] ws,
                         input bit fl);
    st_t st;
    int  n;
    bit  run;
    ment_t e;
    st.cnt = mq.size();
    st.rdy = (D - mq.size()) >= 2;
    st.r0  = 4'(mtail);
    st.r1  = 4'(mtail + 1);
    n = 0;
    if (fl) begin
      mq.delete();
      mtail = 0;
    end else begin
      while (n < 2 && n < mq.size() && mq[n].cmp) n++;
      for (int c = 0; c < n; c++) begin
        exp_cm.push_back('{mq[0].d, mq[0].skp});
        void'(mq.pop_front());
      end
      for (int k = 0; k < 4; k++) begin
        if (wv[k]) begin
          foreach (mq[q]) begin
            if (mq[q].idx == wi[k]) begin
              mq[q].cmp = 1'b1;
              mq[q].skp = ws[k];
            end
          end
        end
      end
      run = st.rdy;
      for (int i = 0; i < 2; i++) begin
        run = run & ev[i];
        if (run) begin
          e.idx = 4'(mtail);
          e.d   = '{enq_pc[i], enq_instr[i], enq_lrd[i],
                    enq_prd[i], enq_old_prd[i], enq_need_to_wb[i]};
          e.cmp = 1'b0;
          e.skp = 1'b0;
          mq.push_back(e);
          mtail = (mtail + 1) % 16;
        end
      end
    end
    st.ncm = n;
    exp_st.push_back(st);
  endtask

  // Called just after a rising edge; drives one cycle of inputs.
  task automatic step(input logic [1:0] ev, input logic [3:0] wv,
                      input logic [3:0][3:0] wi, input logic [3:0] ws,
                      input bit fl);
    enq_valid = ev;
    wb_valid  = wv;
    wb_robidx = wi;
    wb_skip   = ws;
    flush     = fl;
    for (int i = 0; i < 2; i++) begin
      enq_pc[i]         = $urandom;
      enq_instr[i]      = $urandom;
      enq_lrd[i]        = lreg_t'($urandom);
      enq_prd[i]        = preg_t'($urandom);
      enq_old_prd[i]    = preg_t'($urandom);
      enq_need_to_wb[i] = 1'($urandom);
    end
    predict(ev, wv, wi, ws, fl);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(2'b00, 4'b0000, '0, 4'b0000, 1'b0);
  endtask

  task automatic do_rst();
    reset_n   = 1'b0;
    enq_valid = '0;
    wb_valid  = '0;
    flush     = 1'b0;
    mq.delete();
    mtail = 0;
    exp_st.push_back('{0, 1'b1, 4'd0, 4'd1, 0});
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compares status and commit lanes each cycle.
  always @(negedge clock) begin
    st_t st;
    cm_t cm;
    if (exp_st.size() > 0) begin
      st = exp_st.pop_front();
      chk("count", count, st.cnt);
      chk("full", full, st.cnt == D);
      chk("empty", empty, st.cnt == 0);
      chk("enq_ready", enq_ready, st.rdy);
      chk("robidx0", enq_robidx[0], st.r0);
      chk("robidx1", enq_robidx[1], st.r1);
      chk("commit_valid", commit_valid,
          (st.ncm == 2) ? 2'b11 : (st.ncm == 1) ? 2'b01 : 2'b00);
      for (int j = 0; j < st.ncm; j++) begin
        cm = exp_cm.pop_front();
        chk("commit_pc", commit_pc[j], cm.d.pc);
        chk("commit_instr", commit_instr[j], cm.d.instr);
        chk("commit_lrd", commit_lrd[j], cm.d.lrd);
        chk("commit_prd", commit_prd[j], cm.d.prd);
        chk("commit_old_prd", commit_old_prd[j], cm.d.old_prd);
        chk("commit_nwb", commit_need_to_wb[j], cm.d.need_to_wb);
        chk("commit_skip", commit_skip[j], cm.skp);
      end
    end
  end

  initial begin
    logic [1:0]      ev;
    logic [3:0]      wv;
    logic [3:0][3:0] wi;
    logic [3:0]      ws;
    bit              fl;
    checks = 0;
    errors = 0;
    mtail  = 0;
    reset_n = 1'b0;
    enq_valid = '0;
    enq_pc = '0;
    enq_instr = '0;
    enq_lrd = '0;
    enq_prd = '0;
    enq_old_prd = '0;
    enq_need_to_wb = '0;
    wb_valid = '0;
    wb_robidx = '0;
    wb_skip = '0;
    flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // two-lane enqueue, out-of-order writeback, dual commit
    step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    step(2'b00, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, 4'b0000, 1'b0);
    step(2'b00, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd0}, 4'b0000, 1'b0);
    idle();
    // fill to full (indices 2..9 wrap past slot 7), refused enq
    repeat (4) step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    // ports 1 and 2 both hit idx3, higher port sets skip
    step(2'b00, 4'b1111, {4'd4, 4'd3, 4'd3, 4'd2}, 4'b0100, 1'b0);
    // commit 2 while full with enq requested
    step(2'b11, 4'b1111, {4'd8, 4'd7, 4'd6, 4'd5}, 4'b0000, 1'b0);
    step(2'b00, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, 4'b0000, 1'b0);
    repeat (4) idle();
    // five entries, two completed, then flush with enq and wb
    step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    step(2'b01, 4'b0011, {4'd0, 4'd0, 4'd11, 4'd10}, 4'b0000, 1'b0);
    step(2'b11, 4'b1111, {4'd13, 4'd12, 4'd11, 4'd10}, 4'b1010, 1'b1);
    idle();
    // reset in the middle of traffic
    step(2'b11, 4'b0000, '0, 4'b0000, 1'b0);
    step(2'b11, 4'b0011, {4'd0, 4'd0, 4'd1, 4'd0}, 4'b0000, 1'b0);
    do_rst();
    idle();

    for (int c = 0; c < 600; c++) begin
      ev = 2'($urandom);
      fl = ($urandom_range(0, 39) == 0);
      ws = 4'($urandom);
      wv = '0;
      wi = '0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            wv[k] = 1'b1;
            wi[k] = mq[$urandom_range(0, mq.size() - 1)].idx;
          end else if (mq.size() < D) begin
            wv[k] = 1'b1;
            wi[k] = 4'(mtail);
          end
        end
      end
      if (c == 300) do_rst();
      else step(ev, wv, wi, ws, fl);
    end
    repeat (3) idle();
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
